memory_stream_scanner: RTL and testbench

Parametrised streaming reader that walks a synchronous 1-cycle-latency memory from a programmable base address with a programmable stride and element count. Returned words are buffered in an internal prefetch FIFO and presented on a valid/ready stream. It sits between a local memory bank and a Versat datapath unit. It generalises the single-value scanner with stride, length, back-pressure, completion signalling and optional looping.

---
 rtl/memory_stream_scanner.sv | 161 ++++++++++++++++
 tb/tb_memory_stream_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stream_scanner.sv
// Strided memory reader feeding a valid/ready stream through a small prefetch FIFO.
// Define MEMORY_STREAM_SCANNER_LOOP_EN to add loop_i (restart at base instead of finishing).
//
// state | meaning
// IDLE  | waiting for start_i
// SCAN  | issuing reads while the FIFO has credit
// DRAIN | all reads issued, waiting for FIFO and in-flight read to empty

module memory_stream_scanner #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [LEN_W-1:0]  length_i,
`ifdef MEMORY_STREAM_SCANNER_LOOP_EN
    input  logic              loop_i,
`endif
    output logic [ADDR_W-1:0] addr_o,
    output logic              enable_o,
    input  logic [DATA_W-1:0] dataIn_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  stride_q;
    logic [LEN_W-1:0]   length_q;
    logic [LEN_W-1:0]   issued;
    logic               inflight;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic               issue;
    logic               last_issue;
    logic               loop_req;
    logic [CNT_W:0]     credit;
    logic [ADDR_W-1:0]  step;

`ifdef MEMORY_STREAM_SCANNER_LOOP_EN
    assign loop_req = loop_i;
`else
    assign loop_req = 1'b0;
`endif

    // credit counts words that will occupy the FIFO after this edge
    always_comb begin
        valid_o    = (count != '0);
        data_o     = mem[rd_ptr];
        pop        = valid_o & ready_i;
        push       = inflight;
        credit     = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        enable_o   = (state == SCAN) && (credit < (CNT_W+1)'(FIFO_DEPTH));
        issue      = enable_o;
        last_issue = issue && (issued == length_q - LEN_W'(1));
        step       = stride_q * BYTES;
        busy_o     = (state != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            base_q   <= '0;
            stride_q <= '0;
            length_q <= '0;
            issued   <= '0;
            addr_o   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            done_o   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_i) begin
            state    <= IDLE;
            issued   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            inflight <= issue;
            if (push) begin
                mem[wr_ptr] <= dataIn_i;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (length_i != '0) begin
                            base_q   <= base_i;
                            stride_q <= stride_i;
                            length_q <= length_i;
                            addr_o   <= base_i;
                            issued   <= '0;
                            state    <= SCAN;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (last_issue) begin
                        if (loop_req) begin
                            addr_o <= base_q;
                            issued <= '0;
                        end else begin
                            addr_o <= addr_o + step;
                            issued <= issued + LEN_W'(1);
                            state  <= DRAIN;
                        end
                    end else if (issue) begin
                        addr_o <= addr_o + step;
                        issued <= issued + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (credit == '0) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stream_scanner.sv
// Self-checking bench for memory_stream_scanner: vector table plus scoreboard of read words.
module tb_memory_stream_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        start;
    logic [9:0]  base;
    logic [9:0]  stride;
    logic [9:0]  length;
    logic [9:0]  addr;
    logic        enable;
    logic [31:0] rdata;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] exp_q[$];
    int          issue_idx;
    int          beats;
    int          total_exp;
    logic [9:0]  last_addr;
    logic [9:0]  cur_base;
    logic [9:0]  cur_stride;
    logic [9:0]  cur_len;

`ifdef MEMORY_STREAM_SCANNER_LOOP_EN
    logic loop_on = 1'b0;
    logic loop_sig;
    assign loop_sig = loop_on && (issue_idx + 1 < total_exp);
`endif

    memory_stream_scanner dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .start_i  (start),
        .base_i   (base),
        .stride_i (stride),
        .length_i (length),
`ifdef MEMORY_STREAM_SCANNER_LOOP_EN
        .loop_i   (loop_sig),
`endif
        .addr_o   (addr),
        .enable_o (enable),
        .dataIn_i (rdata),
        .data_o   (data),
        .valid_o  (valid),
        .ready_i  (ready),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] word_at(input logic [9:0] a);
        return {16'hC0DE, 6'b0, a};
    endfunction

    function automatic logic [9:0] exp_addr(input int idx);
        int a;
        a = int'(cur_base) + (idx % int'(cur_len)) * int'(cur_stride) * 4;
        return 10'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // memory bank: one-cycle read latency
    always @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (enable) rdata <= word_at(addr);
    end

    // scoreboard: expected word pushed at issue, compared at handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (enable) begin
                chk("issue_addr", 32'(addr), 32'(exp_addr(issue_idx)));
                exp_q.push_back(word_at(addr));
                last_addr = addr;
                issue_idx++;
            end
            if (valid && ready) begin
                beats++;
                if (exp_q.size() == 0) chk("sb_underflow", 32'(data), 32'hFFFF_FFFF);
                else chk("beat_data", data, exp_q.pop_front());
            end
        end
    end

    task automatic start_scan(input logic [9:0] b, input logic [9:0] s, input logic [9:0] l);
        cur_base   = b;
        cur_stride = s;
        cur_len    = l;
        issue_idx  = 0;
        beats      = 0;
        exp_q.delete();
        @(posedge clk); #1;
        base = b; stride = s; length = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_scan(input logic [9:0] b, input logic [9:0] s, input logic [9:0] l,
                            input int total, input int exp_lat, input logic [9:0] exp_last,
                            input int hold);
        int  t0;
        bit  got;
        bit  held;
        logic [31:0] ref_data;
        total_exp = total;
        start_scan(b, s, l);
        t0   = cycle;
        got  = 0;
        held = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk); #1;
            if (done) got = 1;
            else if (hold > 0 && !held && beats == 1) begin
                held = 1;
                @(posedge clk); #1;
                ready = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk); #1;
                    chk("hold_valid", 32'(valid), 32'd1);
                    if (h == 0) ref_data = data;
                    else chk("hold_data_stable", data, ref_data);
                    if (h == hold - 1) chk("hold_enable_low", 32'(enable), 32'd0);
                end
                @(posedge clk); #1;
                ready = 1'b1;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        if (exp_lat >= 0) chk("done_latency", 32'(cycle - t0), 32'(exp_lat));
        chk("beat_count", 32'(beats), 32'(total));
        chk("issue_count", 32'(issue_idx), 32'(total));
        chk("last_addr", 32'(last_addr), 32'(exp_last));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [9:0] b;
        logic [9:0] s;
        logic [9:0] l;
        logic [9:0] last;
        int         lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0;
        vecs[0] = '{b: 10'h010, s: 10'd1,     l: 10'd4, last: 10'h01C, lat: 6};
        vecs[1] = '{b: 10'h3F0, s: 10'd3,     l: 10'd3, last: 10'h008, lat: 5};
        vecs[2] = '{b: 10'h100, s: 10'd0,     l: 10'd3, last: 10'h100, lat: 5};
        vecs[3] = '{b: 10'h200, s: 10'd2,     l: 10'd1, last: 10'h200, lat: 3};
        vecs[4] = '{b: 10'h000, s: 10'h3FF,   l: 10'd5, last: 10'h3F0, lat: 7};

        rst = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b1;
        base = '0; stride = '0; length = '0;
        cur_base = '0; cur_stride = '0; cur_len = 10'd1;
        issue_idx = 0; beats = 0; total_exp = 0; last_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_addr",   32'(addr),   32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_data",   data,        32'd0);
        chk("rst_valid",  32'(valid),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_scan(vecs[i].b, vecs[i].s, vecs[i].l, int'(vecs[i].l), vecs[i].lat, vecs[i].last, 0);
        end

        // back-pressure: consumer stalls 5 cycles after the first beat
        run_scan(10'h040, 10'd1, 10'd6, 6, -1, 10'h054, 5);

        // zero-length start
        start_scan(10'h080, 10'd1, 10'd0);
        @(negedge clk); #1;
        chk("len0_done",   32'(done),   32'd1);
        chk("len0_enable", 32'(enable), 32'd0);
        chk("len0_busy",   32'(busy),   32'd0);
        @(negedge clk); #1;
        chk("len0_done_pulse", 32'(done), 32'd0);
        chk("len0_enable2",    32'(enable), 32'd0);

        // abort after two of eight beats
        total_exp = 8;
        start_scan(10'h0C0, 10'd1, 10'd8);
        t0 = 0;
        while (beats < 2 && t0 < 50) begin
            @(negedge clk); #1;
            t0++;
        end
        chk("clear_reached_two_beats", 32'(beats), 32'd2);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk); #1;
        chk("clear_valid", 32'(valid), 32'd0);
        chk("clear_busy",  32'(busy),  32'd0);
        chk("clear_done",  32'(done),  32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("clear_no_done", 32'(done), 32'd0);
        end
        exp_q.delete();
        run_scan(10'h0C0, 10'd1, 10'd3, 3, 5, 10'h0C8, 0);

`ifdef MEMORY_STREAM_SCANNER_LOOP_EN
        loop_on = 1'b1;
        run_scan(10'h120, 10'd1, 10'd2, 6, 8, 10'h124, 0);
        loop_on = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
